norm_round: RTL

NORM_ROUND -- requirements
Module: norm_round

---
 rtl/norm_round_pkg.sv | 34 +++
 rtl/lzc64.sv | 20 ++
 rtl/vfpu_defs.vh | 11 +
 rtl/norm_round.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/norm_round_pkg.sv
// rtl/norm_round_pkg.sv - types and constants shared by norm_round and lzc64
package norm_round_pkg;
`include "vfpu_defs.vh"

    localparam int MANT_W    = `VFPU_MANT_W;
    localparam int EXP_W     = `VFPU_EXP_W;
    localparam int FRAC_W    = `VFPU_FRAC_W;
    localparam int KEEP_W    = FRAC_W + 1;     // hidden bit + fraction
    localparam int LZ_W      = 7;              // counts 0..64
    localparam int OUT_EXP_W = 8;

    localparam logic signed [EXP_W-1:0] EXP_MAX_S  = EXP_W'(`VFPU_EXP_MAX);
    localparam logic signed [EXP_W-1:0] EXP_ZERO_S = '0;

    // Stage-1 result: normalized significand already reduced to kept/guard/sticky.
    typedef struct packed {
        logic              sign;
        logic              zero;
        logic [EXP_W-1:0]  exp;
        logic [KEEP_W-1:0] kept;
        logic              guard;
        logic              sticky;
    } s1_t;

    typedef struct packed {
        logic                 sign;
        logic [OUT_EXP_W-1:0] exp;
        logic [FRAC_W-1:0]    frac;
        logic                 inexact;
        logic                 overflow;
        logic                 underflow;
        logic                 zero;
    } res_t;
endpackage

// File: rtl/lzc64.sv
// rtl/lzc64.sv - 64-bit leading-zero counter
// Ports: mant (64-bit operand), cnt (leading zeros, 64 when mant is all zero).
module lzc64
    import norm_round_pkg::*;
(
    input  logic [MANT_W-1:0] mant,
    output logic [LZ_W-1:0]   cnt
);

    // Scan LSB to MSB so the highest set bit wins.
    always_comb begin
        cnt = LZ_W'(MANT_W);
        for (int i = 0; i < MANT_W; i++) begin
            if (mant[i]) begin
                cnt = LZ_W'(MANT_W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/vfpu_defs.vh
// rtl/vfpu_defs.vh - shared widths and exponent constants for the vector FPU datapath
`ifndef VFPU_DEFS_VH
`define VFPU_DEFS_VH

`define VFPU_MANT_W  64
`define VFPU_EXP_W   10
`define VFPU_FRAC_W  23
`define VFPU_BIAS    127
`define VFPU_EXP_MAX 255

`endif

// File: rtl/norm_round.sv
// rtl/norm_round.sv - two-stage normalize, round-to-nearest-even and pack to single precision
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   in_valid/in_ready               operand handshake
//   in_sign, in_exp_tmp[9:0]        sign, biased exponent for a leading 1 at in_mant[63]
//   in_mant[63:0], in_sticky        unnormalized magnitude, OR of bits dropped upstream
//   out_valid/out_ready             result handshake
//   out_sign, out_exp[7:0], out_frac[22:0]                   packed result
//   out_inexact, out_overflow, out_underflow, out_zero      status flags
// Build option: NORM_ROUND_DENORM_EN enables denormal results; otherwise tiny results flush to zero.
module norm_round
    import norm_round_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sign,
    input  logic [EXP_W-1:0]     in_exp_tmp,
    input  logic [MANT_W-1:0]    in_mant,
    input  logic                 in_sticky,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sign,
    output logic [OUT_EXP_W-1:0] out_exp,
    output logic [FRAC_W-1:0]    out_frac,
    output logic                 out_inexact,
    output logic                 out_overflow,
    output logic                 out_underflow,
    output logic                 out_zero
);

    logic [LZ_W-1:0]   lz;
    logic [MANT_W-1:0] mant_n;
    logic              s2_ready;

    s1_t  s1_q, s1_d;
    logic s1_valid_q, s1_valid_d;
    res_t out_q, out_d;
    logic out_valid_q, out_valid_d;

    logic [KEEP_W-1:0]       kept;
    logic                    guard;
    logic                    sticky;
    logic                    round_up;
    logic [KEEP_W:0]         sum;
    logic signed [EXP_W-1:0] exp_r;
    res_t                    res;

`ifdef NORM_ROUND_DENORM_EN
    localparam int SH_MAX = 26;
    logic                       tiny;
    logic [EXP_W:0]             sh_full;
    logic [4:0]                 sh;
    logic [KEEP_W+SH_MAX:0]     ext;
`endif

    lzc64 u_lzc64 (
        .mant (in_mant),
        .cnt  (lz)
    );

    // Stage 1: count, shift, exponent adjust.
    always_comb begin
        s2_ready   = !out_valid_q || out_ready;
        in_ready   = !s1_valid_q || s2_ready;
        mant_n     = in_mant << lz;
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_d.sign   = in_sign;
                s1_d.zero   = (in_mant == '0);
                s1_d.exp    = in_exp_tmp - EXP_W'(lz);
                s1_d.kept   = mant_n[MANT_W-1 -: KEEP_W];
                s1_d.guard  = mant_n[MANT_W-1-KEEP_W];
                s1_d.sticky = (|mant_n[MANT_W-2-KEEP_W:0]) | in_sticky;
            end
        end
    end

    // Stage 2: round and pack.
    always_comb begin
        kept   = s1_q.kept;
        guard  = s1_q.guard;
        sticky = s1_q.sticky;
`ifdef NORM_ROUND_DENORM_EN
        // Tiny results are denormalized before rounding so the rounding sees the real LSB.
        tiny    = $signed(s1_q.exp) <= EXP_ZERO_S;
        sh_full = {{EXP_W{1'b0}}, 1'b1} - {s1_q.exp[EXP_W-1], s1_q.exp};
        sh      = (sh_full > (EXP_W+1)'(SH_MAX)) ? 5'(SH_MAX) : sh_full[4:0];
        ext     = {s1_q.kept, s1_q.guard, {SH_MAX{1'b0}}} >> sh;
        if (tiny) begin
            kept   = ext[KEEP_W+SH_MAX:SH_MAX+1];
            guard  = ext[SH_MAX];
            sticky = s1_q.sticky | (|ext[SH_MAX-1:0]);
        end
`endif
        round_up = guard & (sticky | kept[0]);
        sum      = {1'b0, kept} + {{KEEP_W{1'b0}}, round_up};
        exp_r    = s1_q.exp + {{(EXP_W-1){1'b0}}, sum[KEEP_W]};

        res      = '0;
        res.sign = s1_q.sign;
        if (s1_q.zero) begin
            res.zero = 1'b1;
        end
`ifdef NORM_ROUND_DENORM_EN
        else if (tiny) begin
            // A carry into the hidden position promotes the denormal to exponent 1.
            res.exp       = {{(OUT_EXP_W-1){1'b0}}, sum[KEEP_W-1]};
            res.frac      = sum[FRAC_W-1:0];
            res.inexact   = guard | sticky;
            res.underflow = guard | sticky;
            res.zero      = (sum[KEEP_W-1:0] == '0);
        end
`endif
        else if (exp_r >= EXP_MAX_S) begin
            res.exp      = '1;
            res.overflow = 1'b1;
            res.inexact  = 1'b1;
        end else if (exp_r <= EXP_ZERO_S) begin
            res.zero      = 1'b1;
            res.underflow = 1'b1;
            res.inexact   = 1'b1;
        end else begin
            res.exp     = exp_r[OUT_EXP_W-1:0];
            // Carry-out means 1.000..., so renormalize by one (fraction becomes zero).
            res.frac    = sum[KEEP_W] ? sum[FRAC_W:1] : sum[FRAC_W-1:0];
            res.inexact = guard | sticky;
        end

        out_valid_d = out_valid_q;
        out_d       = out_q;
        if (s2_ready) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_d = res;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_q        <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_q        <= s1_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_sign      = out_q.sign;
    assign out_exp       = out_q.exp;
    assign out_frac      = out_q.frac;
    assign out_inexact   = out_q.inexact;
    assign out_overflow  = out_q.overflow;
    assign out_underflow = out_q.underflow;
    assign out_zero      = out_q.zero;

endmodule
